wb_sram_target: RTL and testbench

- Wishbone B4 registered-feedback slave (responder) backed by an on-chip synchronous SRAM.
- Sits on a slave port of the wb interconnects (e.g. s0); completes classic single transfers and CTI/BTE incrementing bursts (linear, wrap4/8/16).
- Addresses outside its window get a one-cycle ERR, so it can also act as a bounded default slave.

---
 rtl/wb_target_pkg.sv | 39 +++
 rtl/wb_if.sv | 28 ++
 rtl/wb_sram_target_array.sv | 44 ++++
 rtl/wb_sram_target.sv | 118 +++++++++++
 tb/tb_wb_sram_target.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_target_pkg.sv
// Shared Wishbone target types: CTI/BTE codes, FSM states
// and the burst address sequencer used by wb_sram_target.
package wb_target_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST,
    ERR
  } wb_state_e;

  // Wrap modes only step the low 2/3/4 bits; the caller
  // truncates to its word-index width for linear wrap.
  function automatic logic [31:0] bte_next(
    input logic [31:0] addr,
    input logic [1:0]  bte
  );
    logic [31:0] n;
    n = addr;
    case (bte)
      BTE_LINEAR: n = addr + 32'd1;
      BTE_WRAP4:  n[1:0] = addr[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = addr[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = addr[3:0] + 4'd1;
      default:    n = addr;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle.
// slave modport: ADR/DAT_W/SEL/CYC/STB/WE/CTI/BTE in, DAT_R/ACK/ERR out.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic [DW-1:0]   DAT_R;
  logic            ACK;
  logic            ERR;

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_target_array.sv
// Word array with byte-enable write and registered read.
// Ports: clk_i, we_i/waddr_i/be_i/wdata_i write, raddr_i/rdata_o read.
module wb_sram_target_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int BW = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] merged;

  // Write-first: a read of the word being written sees
  // the freshly enabled bytes.
  always_comb begin
    merged = mem_q[raddr_i];
    for (int b = 0; b < BW; b++) begin
      if (be_i[b]) merged[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BW; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (we_i && (waddr_i == raddr_i)) rdata_q <= merged;
    else rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_target.sv
// Wishbone B4 registered-feedback SRAM slave, classic + bursts.
// Ports: clk, rst (sync, high), s (wb_if.slave bus port).
module wb_sram_target
  import wb_target_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  s
);

  localparam int OB  = $clog2(WB_DATA_WIDTH / 8);
  localparam int TOP = OB + MEM_ADDR_BITS;

  typedef logic [MEM_ADDR_BITS-1:0] idx_t;

  wb_state_e state_q, state_d;
  idx_t      baddr_q, baddr_d;
  idx_t      idx;
  idx_t      nxt;
  idx_t      waddr;
  idx_t      raddr;
  logic      in_range;
  logic      req;
  logic      ack;
  logic      err;
  logic      we;
  logic [WB_DATA_WIDTH-1:0] rdata;
  logic      unused_adr;

  assign idx      = s.ADR[TOP-1:OB];
  assign in_range = s.ADR[WB_ADDR_WIDTH-1:TOP]
                 == BASE_ADDR[WB_ADDR_WIDTH-1:TOP];
  assign req      = s.CYC & s.STB;
  assign nxt      = idx_t'(bte_next(32'(baddr_q), s.BTE));
  assign unused_adr = ^s.ADR[OB-1:0];

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    ack     = 1'b0;
    err     = 1'b0;
    we      = 1'b0;
    waddr   = idx;
    raddr   = idx;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (!in_range) begin
            state_d = ERR;
          end else if (s.CTI == CTI_INCR) begin
            state_d = BURST;
            baddr_d = idx;
          end else begin
            state_d = SINGLE;
          end
        end
      end
      SINGLE: begin
        ack     = req;
        we      = req & s.WE;
        state_d = IDLE;
      end
      BURST: begin
        ack   = req;
        waddr = baddr_q;
        raddr = baddr_q;
        if (!s.CYC) begin
          state_d = IDLE;
        end else if (req) begin
          we      = s.WE;
          baddr_d = nxt;
          // Prefetch the next beat so data stays zero-wait.
          raddr   = nxt;
          if (s.CTI == CTI_EOB) state_d = IDLE;
        end
      end
      ERR: begin
        err     = s.CYC;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
    end
  end

  wb_sram_target_array #(
    .AW (MEM_ADDR_BITS),
    .DW (WB_DATA_WIDTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .be_i    (s.SEL),
    .wdata_i (s.DAT_W),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Read data is only presented while a data phase is live.
  assign s.DAT_R = (state_q == SINGLE || state_q == BURST)
                 ? rdata : '0;
  assign s.ACK   = ack;
  assign s.ERR   = err;

endmodule

// File: tb/tb_wb_sram_target.sv
// Directed self-checking bench for wb_sram_target:
// classic, byte enables, linear/wrap bursts, ERR, reset abort.
module tb_wb_sram_target;
  import wb_target_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(32)) bus ();

  wb_sram_target #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .MEM_ADDR_BITS (10),
    .BASE_ADDR     (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] model [1024];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.CYC   = 1'b0;
    bus.STB   = 1'b0;
    bus.WE    = 1'b0;
    bus.ADR   = '0;
    bus.DAT_W = '0;
    bus.SEL   = '0;
    bus.CTI   = CTI_CLASSIC;
    bus.BTE   = BTE_LINEAR;
  endtask

  task automatic classic(input logic [31:0] adr,
                         input logic [31:0] dat,
                         input logic [3:0] sel,
                         input logic wr,
                         output logic [31:0] rd,
                         output logic got_err,
                         output int lat);
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = wr;
    bus.ADR = adr; bus.DAT_W = dat; bus.SEL = sel;
    bus.CTI = CTI_CLASSIC; bus.BTE = BTE_LINEAR;
    lat = -1; got_err = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ACK || bus.ERR) begin
        lat = i;
        got_err = bus.ERR;
        rd = bus.DAT_R;
        check("ack_err_excl", 32'(bus.ACK & bus.ERR), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rsp_drop", 32'(bus.ACK | bus.ERR), 32'd0);
    end
    idle_bus();
  endtask

  task automatic wr(input logic [31:0] adr,
                    input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] rd;
    logic e;
    int lat;
    classic(adr, dat, sel, 1'b1, rd, e, lat);
    check("wr_lat", 32'(lat), 32'd1);
    check("wr_err", 32'(e), 32'd0);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) model[adr[11:2]][b*8 +: 8] = dat[b*8 +: 8];
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] adr,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic e;
    int lat;
    classic(adr, 32'h0, 4'h1, 1'b0, rd, e, lat);
    check("rd_lat", 32'(lat), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic burst_rd(input logic [31:0] adr,
                          input logic [1:0] bte,
                          input int n,
                          input int wait_at,
                          input logic [9:0] exp [8]);
    int beat;
    int cyc;
    logic waited;
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0;
    bus.ADR = adr; bus.SEL = 4'hF;
    bus.CTI = CTI_INCR; bus.BTE = bte;
    @(negedge clk);
    check("brst_idle_ack", 32'(bus.ACK), 32'd0);
    beat = 0; cyc = 0; waited = 1'b0;
    while (beat < n && cyc < 3 * n + 4) begin
      @(posedge clk); #1;
      cyc++;
      if (beat == wait_at && !waited) begin
        bus.STB = 1'b0;
        waited = 1'b1;
      end else begin
        bus.STB = 1'b1;
      end
      bus.CTI = (beat == n - 1) ? CTI_EOB : CTI_INCR;
      @(negedge clk);
      if (!bus.STB) begin
        check("brst_wait_ack", 32'(bus.ACK), 32'd0);
      end else if (bus.ACK) begin
        check("brst_data", bus.DAT_R, model[exp[beat]]);
        beat++;
      end else begin
        check("brst_ack", 32'(bus.ACK), 32'd1);
      end
    end
    check("brst_beats", 32'(beat), 32'(n));
    @(posedge clk); #1;
    @(negedge clk);
    check("brst_end_ack", 32'(bus.ACK), 32'd0);
    idle_bus();
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat;

    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(bus.ACK), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);
    check("rst_dat", bus.DAT_R, 32'd0);

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    classic(32'h10, 32'h0, 4'hF, 1'b0, rd, e, lat);
    check("cls_rd_lat", 32'(lat), 32'd1);
    check("cls_rd_dat", rd, 32'hDEADBEEF);
    check("cls_rd_err", 32'(e), 32'd0);

    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'b0101);
    rd_chk("sel_merge", 32'h20, 32'h11BB33DD);

    for (int i = 0; i < 8; i++) begin
      wr(32'h100 + 32'(4 * i), 32'hC0DE0040 + 32'(i), 4'hF);
    end

    burst_rd(32'h100, BTE_LINEAR, 4, -1,
             '{10'h40, 10'h41, 10'h42, 10'h43,
               10'h0, 10'h0, 10'h0, 10'h0});
    burst_rd(32'h100, BTE_LINEAR, 4, 2,
             '{10'h40, 10'h41, 10'h42, 10'h43,
               10'h0, 10'h0, 10'h0, 10'h0});
    burst_rd(32'h108, BTE_WRAP4, 4, -1,
             '{10'h42, 10'h43, 10'h40, 10'h41,
               10'h0, 10'h0, 10'h0, 10'h0});
    burst_rd(32'h11C, BTE_WRAP8, 8, -1,
             '{10'h47, 10'h40, 10'h41, 10'h42,
               10'h43, 10'h44, 10'h45, 10'h46});

    wr(32'h0, 32'hCAFE0000, 4'hF);
    wr(32'h4, 32'h0BAD0001, 4'hF);
    wr(32'h8, 32'h0BAD0002, 4'hF);
    classic(32'h1000, 32'h12345678, 4'hF, 1'b1, rd, e, lat);
    check("oor_err", 32'(e), 32'd1);
    check("oor_lat", 32'(lat), 32'd1);
    rd_chk("oor_nowrite", 32'h0, 32'hCAFE0000);

    // Burst write aborted by reset on the second ACK edge.
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1;
    bus.ADR = 32'h0; bus.SEL = 4'hF;
    bus.CTI = CTI_INCR; bus.BTE = BTE_LINEAR;
    bus.DAT_W = 32'h1;
    @(negedge clk);
    check("bw_idle_ack", 32'(bus.ACK), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bw_ack0", 32'(bus.ACK), 32'd1);
    @(posedge clk); #1;
    bus.DAT_W = 32'h2;
    @(negedge clk);
    check("bw_ack1", 32'(bus.ACK), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.DAT_W = 32'h3;
    @(negedge clk);
    check("bw_rst_ack", 32'(bus.ACK), 32'd0);
    check("bw_rst_err", 32'(bus.ERR), 32'd0);
    check("bw_rst_dat", bus.DAT_R, 32'd0);
    idle_bus();
    rd_chk("bw_word0", 32'h0, 32'h1);
    rd_chk("bw_word1", 32'h4, 32'h0BAD0001);
    rd_chk("bw_word2", 32'h8, 32'h0BAD0002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
